// File: rtl/pet_bus_pkg.sv
// Shared types and constants for the PET system-bus controller.
package pet_bus_pkg;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_VRAM,
    REG_IO,
    REG_ROM,
    REG_NONE
  } region_t;

  typedef enum logic [2:0] {
    IDLE,
    CPU_ADR,
    CPU_CAP,
    DMA_ADR,
    DMA_CAP
  } bus_state_t;

  localparam logic [15:0] IO_BASE          = 16'hE800;
  localparam logic [16:0] IO_SIZE          = 17'h00800;
  localparam logic [7:0]  OPEN_BUS_DEFAULT = 8'h55;

  function automatic logic in_io_window(input logic [15:0] addr);
    return ({1'b0, addr} >= {1'b0, IO_BASE}) &&
           ({1'b0, addr} < ({1'b0, IO_BASE} + IO_SIZE));
  endfunction

endpackage

// File: rtl/pet_bus_decode.sv
// Priority address decoder: I/O window, ROM, video RAM mirror, RAM, else unmapped.
module pet_bus_decode
  import pet_bus_pkg::*;
#(
  parameter int         RAM_AW   = 15,
  parameter logic [3:0] ROM_BASE = 4'hC
) (
  input  logic [15:0] addr,
  output region_t     region
);

  always_comb begin
    if (in_io_window(addr))
      region = REG_IO;
    else if (addr[15:12] >= ROM_BASE)
      region = REG_ROM;
    else if (addr[15:12] == 4'h8)
      region = REG_VRAM;
    else if ((32'(addr) >> RAM_AW) == 32'd0)
      region = REG_RAM;
    else
      region = REG_NONE;
  end

endmodule

// File: rtl/pet_sysbus.sv
// PET system-bus controller: CPU (paced by ce_1m, priority) and DMA share one
// set of synchronous memory strobes; read data is registered per requester.
//
// state   | meaning
// IDLE    | no access in flight; arbitrate CPU over DMA
// CPU_ADR | latched CPU request on mem_addr/strobes
// CPU_CAP | register CPU read data; doubles as the next arbitration slot
// DMA_ADR | latched DMA request on mem_addr/strobes
// DMA_CAP | register DMA read data, ack next clock; doubles as arbitration slot
module pet_sysbus
  import pet_bus_pkg::*;
#(
  parameter int         RAM_AW     = 15,
  parameter int         VRAM_AW    = 10,
  parameter logic [3:0] ROM_BASE   = 4'hC,
  parameter bit         ROM_DMA_WE = 1'b1,
  parameter logic [7:0] OPEN_BUS   = OPEN_BUS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_1m,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_we,
  output logic [7:0]  cpu_dout,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_din,
  output logic [7:0]  dma_dout,
  output logic        dma_ack,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        ram_we,
  output logic        vram_we,
  output logic        io_we,
  output logic        rom_we,
  output logic        io_rd,
  input  logic [7:0]  ram_q,
  input  logic [7:0]  vram_q,
  input  logic [7:0]  io_q,
  input  logic [7:0]  rom_q
);

  if (RAM_AW < 13 || RAM_AW > 15) begin : g_bad_ram_aw
    $error("pet_sysbus: RAM_AW must be 13..15");
  end
  if (VRAM_AW < 10 || VRAM_AW > 11) begin : g_bad_vram_aw
    $error("pet_sysbus: VRAM_AW must be 10 or 11");
  end
  if (ROM_BASE != 4'hB && ROM_BASE != 4'hC) begin : g_bad_rom_base
    $error("pet_sysbus: ROM_BASE must be B or C");
  end

  bus_state_t  state;
  logic        cpu_pend;
  logic [15:0] pend_addr;
  logic [7:0]  pend_din;
  logic        pend_we;
  logic [15:0] acc_addr;
  logic [7:0]  acc_din;
  logic        acc_we;
  logic        acc_dma;
  region_t     region;
  logic [7:0]  rd_mux;
  logic        in_adr;

  pet_bus_decode #(
    .RAM_AW  (RAM_AW),
    .ROM_BASE(ROM_BASE)
  ) u_decode (
    .addr  (acc_addr),
    .region(region)
  );

  assign mem_addr  = acc_addr;
  assign mem_wdata = acc_din;
  assign in_adr    = (state == CPU_ADR) || (state == DMA_ADR);

  // Strobes follow the state register, so reset clears them at once.
  always_comb begin
    ram_we  = 1'b0;
    vram_we = 1'b0;
    io_we   = 1'b0;
    io_rd   = 1'b0;
    rom_we  = 1'b0;
    if (in_adr) begin
      unique case (region)
        REG_RAM:  ram_we  = acc_we;
        REG_VRAM: vram_we = acc_we;
        REG_IO: begin
          io_we = acc_we;
          io_rd = !acc_we;
        end
        REG_ROM:  rom_we  = acc_we && acc_dma && ROM_DMA_WE;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = OPEN_BUS;
    unique case (region)
      REG_RAM:  rd_mux = ram_q;
      REG_VRAM: rd_mux = vram_q;
      REG_IO:   rd_mux = io_q;
      REG_ROM:  rd_mux = rom_q;
      default:  rd_mux = OPEN_BUS;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cpu_pend  <= 1'b0;
      pend_addr <= '0;
      pend_din  <= '0;
      pend_we   <= 1'b0;
      acc_addr  <= '0;
      acc_din   <= '0;
      acc_we    <= 1'b0;
      acc_dma   <= 1'b0;
      cpu_dout  <= '0;
      dma_dout  <= '0;
      dma_ack   <= 1'b0;
    end else begin
      dma_ack <= 1'b0;
      case (state)
        CPU_ADR, DMA_ADR: begin
          state <= (state == CPU_ADR) ? CPU_CAP : DMA_CAP;
          if (ce_1m) begin
            cpu_pend  <= 1'b1;
            pend_addr <= cpu_addr;
            pend_din  <= cpu_din;
            pend_we   <= cpu_we;
          end
        end
        default: begin
          if (state == CPU_CAP && !acc_we)
            cpu_dout <= rd_mux;
          if (state == DMA_CAP) begin
            dma_ack <= 1'b1;
            if (!acc_we)
              dma_dout <= rd_mux;
          end
          // The request just finished in DMA_CAP must not be re-taken.
          if (ce_1m || cpu_pend) begin
            state    <= CPU_ADR;
            cpu_pend <= 1'b0;
            acc_dma  <= 1'b0;
            acc_addr <= ce_1m ? cpu_addr : pend_addr;
            acc_din  <= ce_1m ? cpu_din  : pend_din;
            acc_we   <= ce_1m ? cpu_we   : pend_we;
          end else if (dma_req && !dma_ack && state != DMA_CAP) begin
            state    <= DMA_ADR;
            acc_dma  <= 1'b1;
            acc_addr <= dma_addr;
            acc_din  <= dma_din;
            acc_we   <= dma_we;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pet_sysbus.sv
// Bench for pet_sysbus: two differently parametrised instances share stimulus
// and are checked against a flat logical memory-map model.
module tb_pet_sysbus;

  localparam int         RAW   [2] = '{15, 13};
  localparam int         VAW   [2] = '{10, 11};
  localparam logic [3:0] RBASE [2] = '{4'hC, 4'hB};
  localparam bit         RDWE  [2] = '{1'b1, 1'b0};
  localparam logic [10:0] VMASK [2] = '{11'h3FF, 11'h7FF};
  localparam logic [7:0] OPENB = 8'h55;
  localparam int R_RAM = 0, R_VRAM = 1, R_IO = 2, R_ROM = 3, R_NONE = 4;
  localparam logic [15:0] EDGE [15] = '{16'h1FFF, 16'h2000, 16'h7FFF, 16'h8000,
    16'h8FFF, 16'h9000, 16'hAFFF, 16'hB000, 16'hBFFF, 16'hC000, 16'hE7FF,
    16'hE800, 16'hEFFF, 16'hF000, 16'hFFFF};

  logic clk = 1'b0;
  logic reset, ce_1m, cpu_we, dma_req, dma_we, mem_init;
  logic [15:0] cpu_addr, dma_addr;
  logic [7:0]  cpu_din, dma_din;
  logic [7:0]  cpu_dout [2], dma_dout [2], mem_wdata [2];
  logic [15:0] mem_addr [2];
  logic        dma_ack [2], ram_we [2], vram_we [2], io_we [2], rom_we [2], io_rd [2];
  logic [7:0]  ram_q [2], vram_q [2], io_q [2], rom_q [2];

  logic [7:0] ram_m   [0:1][0:32767];
  logic [7:0] vram_m  [0:1][0:2047];
  logic [7:0] io_m    [0:1][0:2047];
  logic [7:0] rom_m   [0:1][0:65535];
  logic [7:0] logical [0:1][0:65535];
  logic [7:0] exp_cdout [2];
  logic [7:0] seed;
  int n_pass, n_chk;

  always #5 clk = ~clk;

  pet_sysbus #(.RAM_AW(15), .VRAM_AW(10), .ROM_BASE(4'hC), .ROM_DMA_WE(1'b1),
               .OPEN_BUS(8'h55)) u0 (
    .clk(clk), .reset(reset), .ce_1m(ce_1m), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_we(cpu_we), .cpu_dout(cpu_dout[0]), .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_din(dma_din), .dma_dout(dma_dout[0]), .dma_ack(dma_ack[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .ram_we(ram_we[0]),
    .vram_we(vram_we[0]), .io_we(io_we[0]), .rom_we(rom_we[0]), .io_rd(io_rd[0]),
    .ram_q(ram_q[0]), .vram_q(vram_q[0]), .io_q(io_q[0]), .rom_q(rom_q[0]));

  pet_sysbus #(.RAM_AW(13), .VRAM_AW(11), .ROM_BASE(4'hB), .ROM_DMA_WE(1'b0),
               .OPEN_BUS(8'h55)) u1 (
    .clk(clk), .reset(reset), .ce_1m(ce_1m), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_we(cpu_we), .cpu_dout(cpu_dout[1]), .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_din(dma_din), .dma_dout(dma_dout[1]), .dma_ack(dma_ack[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .ram_we(ram_we[1]),
    .vram_we(vram_we[1]), .io_we(io_we[1]), .rom_we(rom_we[1]), .io_rd(io_rd[1]),
    .ram_q(ram_q[1]), .vram_q(vram_q[1]), .io_q(io_q[1]), .rom_q(rom_q[1]));

  function automatic logic [7:0] hash(input logic [15:0] a);
    logic [7:0] t;
    t = a[15:8] * 8'd29;
    return a[7:0] ^ t ^ seed;
  endfunction

  // Synchronous-read memories and I/O registers seen by each instance.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_init) begin
        for (int j = 0; j < 32768; j++) ram_m[i][j] <= hash(16'(j));
        for (int j = 0; j < 2048; j++) begin
          vram_m[i][j] <= hash(16'h8000 + 16'(j));
          io_m[i][j]   <= hash(16'hE800 + 16'(j));
        end
        for (int j = 0; j < 65536; j++) rom_m[i][j] <= hash(16'(j));
      end else begin
        ram_q[i]  <= ram_m[i][mem_addr[i][14:0]];
        vram_q[i] <= vram_m[i][mem_addr[i][10:0] & VMASK[i]];
        io_q[i]   <= io_m[i][mem_addr[i][10:0]];
        rom_q[i]  <= rom_m[i][mem_addr[i]];
        if (ram_we[i])  ram_m[i][mem_addr[i][14:0]] <= mem_wdata[i];
        if (vram_we[i]) vram_m[i][mem_addr[i][10:0] & VMASK[i]] <= mem_wdata[i];
        if (io_we[i])   io_m[i][mem_addr[i][10:0]] <= mem_wdata[i];
        if (rom_we[i])  rom_m[i][mem_addr[i]] <= mem_wdata[i];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [4:0] stb(input int i);
    return {ram_we[i], vram_we[i], io_we[i], io_rd[i], rom_we[i]};
  endfunction

  function automatic int ref_region(input int i, input logic [15:0] a);
    if (a >= 16'hE800 && a <= 16'hEFFF) return R_IO;
    if (int'(a[15:12]) >= int'(RBASE[i])) return R_ROM;
    if (a[15:12] == 4'h8) return R_VRAM;
    if (int'(a) < (1 << RAW[i])) return R_RAM;
    return R_NONE;
  endfunction

  function automatic logic [15:0] canon(input int i, input logic [15:0] a);
    if (ref_region(i, a) == R_VRAM) return 16'h8000 | {5'b0, a[10:0] & VMASK[i]};
    return a;
  endfunction

  function automatic logic [4:0] exp_strobe(input int i, input logic [15:0] a,
                                            input logic we, input logic dma);
    case (ref_region(i, a))
      R_RAM:   return we ? 5'b10000 : 5'b00000;
      R_VRAM:  return we ? 5'b01000 : 5'b00000;
      R_IO:    return we ? 5'b00100 : 5'b00010;
      R_ROM:   return (we && dma && RDWE[i]) ? 5'b00001 : 5'b00000;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [7:0] ref_read(input int i, input logic [15:0] a);
    if (ref_region(i, a) == R_NONE) return OPENB;
    return logical[i][canon(i, a)];
  endfunction

  task automatic ref_write(input int i, input logic [15:0] a, input logic [7:0] d,
                           input logic dma);
    int r;
    r = ref_region(i, a);
    if (r == R_NONE) return;
    if (r == R_ROM && !(dma && RDWE[i])) return;
    logical[i][canon(i, a)] = d;
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("%s_stb%0d", tag, i), 32'(stb(i)), 0);
      check_eq($sformatf("%s_ack%0d", tag, i), 32'(dma_ack[i]), 0);
      check_eq($sformatf("%s_cdout%0d", tag, i), 32'(cpu_dout[i]), 0);
      check_eq($sformatf("%s_ddout%0d", tag, i), 32'(dma_dout[i]), 0);
      check_eq($sformatf("%s_maddr%0d", tag, i), 32'(mem_addr[i]), 0);
      check_eq($sformatf("%s_mwdata%0d", tag, i), 32'(mem_wdata[i]), 0);
    end
  endtask

  task automatic cpu_access(input logic [15:0] a, input logic we, input logic [7:0] d);
    logic [4:0] es [2];
    @(negedge clk);
    cpu_addr = a; cpu_we = we; cpu_din = d; ce_1m = 1'b1;
    for (int i = 0; i < 2; i++) begin
      es[i] = exp_strobe(i, a, we, 1'b0);
      if (we) ref_write(i, a, d, 1'b0);
      else exp_cdout[i] = ref_read(i, a);
    end
    @(negedge clk);
    ce_1m = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("cpu_stb%0d@%h", i, a), 32'(stb(i)), 32'(es[i]));
      check_eq($sformatf("cpu_maddr%0d", i), 32'(mem_addr[i]), 32'(a));
      if (we) check_eq($sformatf("cpu_wdata%0d", i), 32'(mem_wdata[i]), 32'(d));
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      check_eq($sformatf("cpu_stb_off%0d", i), 32'(stb(i)), 0);
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      check_eq($sformatf("cpu_dout%0d@%h", i, a), 32'(cpu_dout[i]), 32'(exp_cdout[i]));
    repeat (3) @(negedge clk);
  endtask

  task automatic dma_wait(input logic [15:0] a, input logic we, input logic [7:0] d);
    logic [4:0] es [2], got [2];
    logic [7:0] ed [2];
    int cnt [2];
    int lat;
    for (int i = 0; i < 2; i++) begin
      es[i] = exp_strobe(i, a, we, 1'b1);
      got[i] = '0; cnt[i] = 0; ed[i] = ref_read(i, a);
      if (we) ref_write(i, a, d, 1'b1);
    end
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        if (stb(i) != 5'b0) begin
          got[i] |= stb(i);
          cnt[i]++;
        end
      if (dma_ack[0]) begin
        lat = k;
        dma_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
          check_eq($sformatf("dma_ack%0d", i), 32'(dma_ack[i]), 1);
          if (!we) check_eq($sformatf("dma_dout%0d@%h", i, a), 32'(dma_dout[i]), 32'(ed[i]));
        end
      end
    end
    check_eq("dma_latency", lat, 3);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("dma_stb%0d@%h", i, a), 32'(got[i]), 32'(es[i]));
      check_eq($sformatf("dma_stb_cnt%0d", i), cnt[i], (es[i] != 5'b0) ? 1 : 0);
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      check_eq($sformatf("dma_ack_pulse%0d", i), 32'(dma_ack[i]), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic dma_access(input logic [15:0] a, input logic we, input logic [7:0] d);
    @(negedge clk);
    dma_addr = a; dma_we = we; dma_din = d; dma_req = 1'b1;
    dma_wait(a, we, d);
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return EDGE[$urandom_range(0, 14)];
      1:       return 16'($urandom_range(0, 16'h7FFF));
      2:       return 16'h8000 | 16'($urandom_range(0, 16'h0FFF));
      3:       return 16'hE800 | 16'($urandom_range(0, 16'h07FF));
      4:       return 16'hB000 + 16'($urandom_range(0, 16'h4FFF));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] ca, da;
    logic [7:0]  cd, dd;
    logic [7:0]  ed [2];

    seed = 8'($urandom);
    n_pass = 0; n_chk = 0;
    reset = 1'b1; mem_init = 1'b1; ce_1m = 1'b0; cpu_we = 1'b0; dma_req = 1'b0;
    dma_we = 1'b0; cpu_addr = '0; dma_addr = '0; cpu_din = '0; dma_din = '0;
    for (int i = 0; i < 2; i++) begin
      exp_cdout[i] = '0;
      for (int a = 0; a < 65536; a++) logical[i][a] = hash(16'(a));
    end
    @(negedge clk);
    mem_init = 1'b0;
    @(negedge clk);
    check_zero("rst");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // RAM top, VRAM mirror, open bus
    cpu_access(16'h7FFF, 1'b1, 8'hA5);
    cpu_access(16'h8000, 1'b1, 8'h3C);
    cpu_access(16'h7FFF, 1'b0, 8'h00);
    cpu_access(16'h8000, 1'b0, 8'h00);
    cpu_access(16'h8400, 1'b1, 8'h41);
    cpu_access(16'h8000, 1'b0, 8'h00);
    cpu_access(16'hB123, 1'b0, 8'h00);

    // ROM protection and DMA ROM load
    cpu_access(16'hF000, 1'b1, 8'h99);
    cpu_access(16'hF000, 1'b0, 8'h00);
    dma_access(16'hF000, 1'b1, 8'h6E);
    dma_access(16'hF000, 1'b0, 8'h00);
    cpu_access(16'hF000, 1'b0, 8'h00);

    // I/O side effects
    cpu_access(16'hE840, 1'b0, 8'h00);
    cpu_access(16'hE840, 1'b1, 8'hC7);
    cpu_access(16'hE840, 1'b0, 8'h00);
    dma_access(16'hE7FF, 1'b0, 8'h00);

    // Simultaneous ce_1m and dma_req: CPU first, DMA two clocks later
    ca = 16'h8012; cd = 8'($urandom); da = 16'h0456; dd = 8'($urandom);
    @(negedge clk);
    cpu_addr = ca; cpu_we = 1'b1; cpu_din = cd; ce_1m = 1'b1;
    dma_addr = da; dma_we = 1'b1; dma_din = dd; dma_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ref_write(i, ca, cd, 1'b0);
      ref_write(i, da, dd, 1'b1);
    end
    @(negedge clk);
    ce_1m = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("cont_cpu_stb%0d", i), 32'(stb(i)), 32'(exp_strobe(i, ca, 1'b1, 1'b0)));
      check_eq($sformatf("cont_cpu_maddr%0d", i), 32'(mem_addr[i]), 32'(ca));
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) check_eq($sformatf("cont_gap%0d", i), 32'(stb(i)), 0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("cont_dma_stb%0d", i), 32'(stb(i)), 32'(exp_strobe(i, da, 1'b1, 1'b1)));
      check_eq($sformatf("cont_dma_maddr%0d", i), 32'(mem_addr[i]), 32'(da));
      check_eq($sformatf("cont_dma_wdata%0d", i), 32'(mem_wdata[i]), 32'(dd));
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) check_eq($sformatf("cont_ack_early%0d", i), 32'(dma_ack[i]), 0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) check_eq($sformatf("cont_ack%0d", i), 32'(dma_ack[i]), 1);
    dma_req = 1'b0;
    repeat (4) @(negedge clk);
    cpu_access(ca, 1'b0, 8'h00);
    cpu_access(da, 1'b0, 8'h00);

    // ce_1m during DMA_ADR is held pending and served right after DMA_CAP
    da = 16'h0200 | 16'($urandom_range(0, 255)); ca = 16'h1000 | 16'($urandom_range(0, 255));
    @(negedge clk);
    dma_addr = da; dma_we = 1'b0; dma_req = 1'b1;
    for (int i = 0; i < 2; i++) ed[i] = ref_read(i, da);
    @(negedge clk);
    cpu_addr = ca; cpu_we = 1'b0; ce_1m = 1'b1;
    for (int i = 0; i < 2; i++) exp_cdout[i] = ref_read(i, ca);
    @(negedge clk);
    ce_1m = 1'b0;
    check_eq("pend_set0", 32'(u0.cpu_pend), 1);
    check_eq("pend_set1", 32'(u1.cpu_pend), 1);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("pend_ack%0d", i), 32'(dma_ack[i]), 1);
      check_eq($sformatf("pend_ddout%0d", i), 32'(dma_dout[i]), 32'(ed[i]));
      check_eq($sformatf("pend_maddr%0d", i), 32'(mem_addr[i]), 32'(ca));
    end
    dma_req = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++)
      check_eq($sformatf("pend_cdout%0d", i), 32'(cpu_dout[i]), 32'(exp_cdout[i]));
    repeat (3) @(negedge clk);

    // Reset in DMA_ADR of a write: no partial write, request re-served once
    da = 16'h0300 | 16'($urandom_range(0, 255)); dd = 8'($urandom);
    @(negedge clk);
    dma_addr = da; dma_we = 1'b1; dma_din = dd; dma_req = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check_eq($sformatf("rstmid_pre%0d", i), 32'(stb(i)), 32'b10000);
    reset = 1'b1;
    #1;
    check_zero("rstmid");
    @(negedge clk);
    for (int i = 0; i < 2; i++) check_eq($sformatf("rstmid_hold%0d", i), 32'(stb(i)), 0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) exp_cdout[i] = '0;
    dma_wait(da, 1'b1, dd);
    cpu_access(da, 1'b0, 8'h00);

    for (int n = 0; n < 160; n++) begin
      ca = pick_addr();
      cd = 8'($urandom);
      if ($urandom_range(0, 2) == 0) dma_access(ca, 1'($urandom_range(0, 1)), cd);
      else cpu_access(ca, 1'($urandom_range(0, 1)), cd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pet_sysbus.md
# pet_sysbus

Parametrised PET system-bus controller: decodes CPU and DMA addresses into RAM, video RAM, I/O and ROM regions, drives one shared set of memory strobes, and registers read data back to the requester. CPU accesses are paced by `ce_1m` and take priority; the DMA port is served in idle slots through a req/ack handshake. It replaces the fixed 16K/40-column combinational map, supports 8K–32K RAM and 40/80-column video RAM, and allows ROM loading over DMA.

## Interface
- `RAM_AW`, 15: RAM address width. RAM occupies 0000 to 2^RAM_AW−1. Legal values are 13–15.
- `VRAM_AW`, 10: video RAM width (10 gives 1K for 40 columns, 11 gives 2K for 80 columns). Mirrored across 8000–8FFF.
- `ROM_BASE`, 4'hC: top nibble of the lowest ROM address. Legal values are B or C. ROM spans ROM_BASE000–FFFF, excluding the I/O window.
- `ROM_DMA_WE`, 1: 1 lets DMA write the ROM region through `rom_we`.
- `OPEN_BUS`, 8'h55: read value for unmapped addresses.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `ce_1m`  in  1  CPU cycle strobe. The CPU address, data and write enable are sampled when this is high.
- `cpu_addr`  in  16  CPU address.
- `cpu_din`  in  8  CPU write data.
- `cpu_we`  in  1  CPU write enable.
- `cpu_dout`  out  8  registered CPU read data.
- `dma_req`  in  1  DMA request. Held high until `dma_ack`.
- `dma_we`  in  1  DMA write enable.
- `dma_addr`  in  16  DMA address.
- `dma_din`  in  8  DMA write data.
- `dma_dout`  out  8  DMA read data, valid while `dma_ack` is high.
- `dma_ack`  out  1  one-clock completion pulse.
- `mem_addr`  out  16  shared memory address.
- `mem_wdata`  out  8  shared write data.
- `ram_we`, `vram_we`, `io_we`, `rom_we`  out  1 each  one-clock write strobes.
- `io_rd`  out  1  one-clock read strobe for the I/O region (VIA/PIA read side effects).
- `ram_q`, `vram_q`, `io_q`, `rom_q`  in  8 each  synchronous-read data, valid one clock after `mem_addr`.

## Operation
- Region decode is priority-ordered, top-down:
  - E800–EFFF → IO.
  - ROM_BASE000–FFFF → ROM.
  - 8000–8FFF → VRAM; only address bits [VRAM_AW-1:0] are used.
  - Below 2^RAM_AW → RAM.
  - Anything else → NONE.
- Write gating:
  - A write to NONE is ignored.
  - A CPU write to ROM is always ignored.
  - A DMA write to ROM asserts `rom_we` only when ROM_DMA_WE=1.
- Read data returned to the requester:
  - NONE returns OPEN_BUS.
  - Every other region returns the matching `*_q`, captured in the capture state.
- `io_rd` is asserted only for reads of the IO region. It is never asserted for writes or for DMA reads of NONE.
- FSM states are IDLE, CPU_ADR, CPU_CAP, DMA_ADR, DMA_CAP.
  - IDLE → CPU_ADR when `ce_1m` is high, or when `cpu_pend` is set. The CPU address, data and write enable are latched into the access registers.
  - IDLE → DMA_ADR when `dma_req` is high, `ce_1m` is low and `cpu_pend` is clear.
  - CPU_ADR → CPU_CAP → IDLE.
  - DMA_ADR → DMA_CAP → IDLE.
  - In the ADR states, `mem_addr`, `mem_wdata` and the strobes are driven from the latched request.
  - In the CAP states, the read data is registered.
- `ce_1m` arriving outside IDLE sets `cpu_pend` and latches the CPU address, data and write enable. `cpu_pend` is cleared on entry to CPU_ADR.
- Simultaneous `ce_1m` and `dma_req` in IDLE: the CPU is served first.
- A DMA request that loses arbitration stays pending and is served on the next IDLE slot.
- Reset, at any time including mid-access, forces:
  - state IDLE, `cpu_pend` cleared;
  - all strobes and `dma_ack` at 0;
  - `cpu_dout`, `dma_dout`, `mem_addr` and `mem_wdata` at 0.
  - No partial write is issued after reset release. A `dma_req` still high after release is served normally.

## Timing
- CPU, uncontended (`ce_1m` high at clock T):
  - `mem_addr` and strobes valid during T+1.
  - `*_q` valid during T+2.
  - `cpu_dout` updated at the end of T+2 and held until the next CPU read.
  - A CPU write leaves `cpu_dout` unchanged.
- CPU behind a DMA access: worst-case `cpu_dout` latency is 4 clocks after `ce_1m`.
- `ce_1m` spacing must be at least 6 clocks; tighter spacing is unsupported.
- DMA: `dma_ack` pulses in the clock after DMA_CAP, together with a valid `dma_dout`. Minimum request-to-ack latency is 3 clocks.
- `dma_req` must be deasserted, or its address changed, in the clock after `dma_ack`. Otherwise it is treated as a new request.

## Structure
- Package `pet_bus_pkg` holds:
  - `region_t` (REG_RAM, REG_VRAM, REG_IO, REG_ROM, REG_NONE);
  - `bus_state_t`;
  - the I/O window constants (E800 base, 2K size) and the default OPEN_BUS.
- Sub-module `pet_bus_decode`: combinational address → `region_t` decoder, parametrised by RAM_AW and ROM_BASE. It is instantiated once, on the latched access address.

## Test plan
- CPU reads: RAM_AW=15. CPU reads 7FFF and then 8000, with the RAM model returning A5 and the VRAM model returning 3C. Required: `cpu_dout` equals A5 and then 3C, each 3 clocks after `ce_1m`. With RAM_AW=13, a read of 7FFF returns 55.
- VRAM mirror: VRAM_AW=10. CPU writes 41 to 8400. Required: `vram_we` high for one clock with `mem_addr` 8400, and a subsequent read of 8000 returns 41 from the model.
- ROM protection: CPU write to F000 → no strobe. DMA write to F000 with ROM_DMA_WE=1 → `rom_we` pulse and `dma_ack`. With ROM_DMA_WE=0 → `dma_ack` only.
- Contention: `dma_req` and `ce_1m` raised in the same clock. Required: CPU strobes first, DMA strobes 2 clocks later, `dma_ack` at T+5. Next, `ce_1m` arrives during DMA_ADR. Required: `cpu_pend` is set and `cpu_dout` is valid within 4 clocks.
- I/O read: CPU read of E840. Required: a single `io_rd` pulse and `cpu_dout` equal to `io_q`. A write to E840 gives `io_we` and no `io_rd`.
- Reset mid-access: assert `reset` during DMA_ADR of a write. Required: all outputs 0 immediately, with no strobe after release. `dma_req` still high after release is then re-served, giving exactly one write.
